// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use hazard detection and registered
// EX-stage forwarding selects.
// Optional build macro STALL_CNT_EN adds saturating stall/flush event counters.
module id_ex_fwd_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rt,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [3:0]        id_alu_op,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MW  = 2'b01,
    SEL_EM  = 2'b10,
    SEL_IMM = 2'b11
  } fwd_sel_e;

  // Shadow of the instruction leaving EX: it occupies MEM/WB when the
  // instruction now in ID reaches EX.
  logic              mw_valid;
  logic              mw_reg_write;
  logic [REG_AW-1:0] mw_rd;

  logic     haz;
  logic     em_ok;
  logic     mw_ok;
  fwd_sel_e a_sel;
  fwd_sel_e b_sel;

  // Hazard detection and forwarding-select computation for the ID instruction
  always_comb begin
    haz   = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
            ((id_rs == ex_rd) | (id_use_rt & (id_rt == ex_rd)));
    stall = haz & ~flush & rst_n;
    em_ok = ex_valid & ex_reg_write & (ex_rd != '0);
    mw_ok = mw_valid & mw_reg_write & (mw_rd != '0);
    a_sel = SEL_RF;
    b_sel = SEL_RF;
    if (em_ok && id_rs == ex_rd)
      a_sel = SEL_EM;
    else if (mw_ok && id_rs == mw_rd)
      a_sel = SEL_MW;
    if (id_use_imm)
      b_sel = SEL_IMM;
    else if (em_ok && id_rt == ex_rd)
      b_sel = SEL_EM;
    else if (mw_ok && id_rt == mw_rd)
      b_sel = SEL_MW;
  end

  // ID/EX register: reset, then flush/hazard bubble, then normal capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_op    <= '0;
      ex_rd        <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      fwd_a_sel    <= SEL_RF;
      fwd_b_sel    <= SEL_RF;
    end else begin
      ex_alu_op  <= id_alu_op;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      if (flush || haz) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        fwd_a_sel    <= SEL_RF;
        fwd_b_sel    <= SEL_RF;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_reg_write & id_valid;
        ex_mem_read  <= id_mem_read & id_valid;
        ex_mem_write <= id_mem_write & id_valid;
        fwd_a_sel    <= a_sel;
        fwd_b_sel    <= b_sel;
      end
    end
  end

  // MEM/WB shadow advances every cycle, bubbles included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mw_valid     <= 1'b0;
      mw_reg_write <= 1'b0;
      mw_rd        <= '0;
    end else begin
      mw_valid     <= ex_valid;
      mw_reg_write <= ex_reg_write;
      mw_rd        <= ex_rd;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating event counters; a flush masks a coincident stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage with a queue scoreboard of expected
// EX-stage register contents, one entry per clock edge.
module tb_id_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_use_rt, id_use_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [3:0]  id_alu_op;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v, rw, mr, mw;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [31:0] a, b, im;
    logic [1:0]  fa, fb;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];

  id_ex_fwd_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rt(id_use_rt), .id_use_imm(id_use_imm),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, rt, rd,
                       input logic urt, uimm, rw, mr, mw, input logic [3:0] alu,
                       input logic [31:0] im);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_use_rt = urt; id_use_imm = uimm;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_op = alu;
    id_rs_data = 32'hA000_0000 | 32'(rs) | (32'(rd) << 8);
    id_rt_data = 32'hB000_0000 | 32'(rt) | (32'(rd) << 8);
    id_imm = im;
  endtask

  // Expect the currently driven ID instruction to be captured with given selects
  task automatic cap(input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.v = id_valid; e.rw = id_reg_write & id_valid; e.mr = id_mem_read & id_valid;
    e.mw = id_mem_write & id_valid; e.alu = id_alu_op; e.rd = id_rd;
    e.a = id_rs_data; e.b = id_rt_data; e.im = id_imm;
    e.fa = fa; e.fb = fb; e.chk_data = 1'b1;
    sb.push_back(e);
  endtask

  // Expect a bubble; on reset the data fields are also zero
  task automatic bub(input bit rst);
    exp_t e;
    e.v = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.alu = '0; e.rd = '0;
    e.a = '0; e.b = '0; e.im = '0; e.fa = 2'b00; e.fb = 2'b00; e.chk_data = rst;
    sb.push_back(e);
  endtask

  task automatic chk_stall(input logic exp);
    #1;
    check("stall", 32'(stall), 32'(exp));
  endtask

  task automatic tick(input string step);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({step, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({step, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
      check({step, ".ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
      check({step, ".ex_mem_read"}, 32'(ex_mem_read), 32'(e.mr));
      check({step, ".ex_mem_write"}, 32'(ex_mem_write), 32'(e.mw));
      check({step, ".fwd_a_sel"}, 32'(fwd_a_sel), 32'(e.fa));
      check({step, ".fwd_b_sel"}, 32'(fwd_b_sel), 32'(e.fb));
      if (e.chk_data) begin
        check({step, ".ex_alu_op"}, 32'(ex_alu_op), 32'(e.alu));
        check({step, ".ex_rd"}, 32'(ex_rd), 32'(e.rd));
        check({step, ".ex_rs_data"}, ex_rs_data, e.a);
        check({step, ".ex_rt_data"}, ex_rt_data, e.b);
        check({step, ".ex_imm"}, ex_imm, e.im);
      end
    end
  endtask

  initial begin
    // Reset held with a valid instruction at the ID inputs
    rst_n = 1'b0; flush = 1'b0;
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    chk_stall(0);
    bub(1); tick("reset1");
    chk_stall(0);
    bub(1); tick("reset2");
`ifdef STALL_CNT_EN
    check("reset.stall_cnt", stall_cnt, 32'd0);
    check("reset.flush_cnt", flush_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // add r3 <- r1,r2 ; sub r4 <- r3,r5 : EX/MEM forward on A
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    chk_stall(0); cap(2'b00, 2'b00); tick("add_r3");
    drive(1, 5'd3, 5'd5, 5'd4, 1, 0, 1, 0, 0, 4'h2, 32'h0);
    chk_stall(0); cap(2'b10, 2'b00); tick("sub_r4");

    // add r3, nop, or r6 <- r3,r3 : MEM/WB forward on both
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    cap(2'b00, 2'b00); tick("add_r3_b");
    drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 4'h0, 32'h0);
    cap(2'b00, 2'b00); tick("nop");
    drive(1, 5'd3, 5'd3, 5'd6, 1, 0, 1, 0, 0, 4'h3, 32'h0);
    cap(2'b01, 2'b01); tick("or_r6");

    // add r3, add r3, and r10 <- r3,r4 : EX/MEM wins over MEM/WB
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    cap(2'b00, 2'b00); tick("add_r3_c");
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    cap(2'b00, 2'b00); tick("add_r3_d");
    drive(1, 5'd3, 5'd4, 5'd10, 1, 0, 1, 0, 0, 4'h4, 32'h0);
    cap(2'b10, 2'b00); tick("and_r10");

    // lw r7 ; add r8 <- r7,r1 : one stall cycle, one bubble, then MEM/WB forward
    drive(1, 5'd1, 5'd0, 5'd7, 0, 1, 1, 1, 0, 4'h0, 32'h4);
    chk_stall(0); cap(2'b00, 2'b11); tick("lw_r7");
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    chk_stall(1); bub(0); tick("lu_bubble");
`ifdef STALL_CNT_EN
    check("lu.stall_cnt", stall_cnt, 32'd1);
`endif
    chk_stall(0); cap(2'b01, 2'b00); tick("add_r8");

    // Flush coincident with a load-use condition: no stall, bubble
    drive(1, 5'd1, 5'd0, 5'd7, 0, 1, 1, 1, 0, 4'h0, 32'h8);
    cap(2'b00, 2'b11); tick("lw_r7_b");
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    flush = 1'b1;
    chk_stall(0); bub(0); tick("flush_bubble");
    flush = 1'b0;
`ifdef STALL_CNT_EN
    check("flush.stall_cnt", stall_cnt, 32'd1);
    check("flush.flush_cnt", flush_cnt, 32'd1);
`endif

    // addi r0 ; addi r9 <- r0,#0x10 : register zero never forwards
    drive(1, 5'd1, 5'd0, 5'd0, 0, 1, 1, 0, 0, 4'h1, 32'h1);
    chk_stall(0); cap(2'b00, 2'b11); tick("addi_r0");
    drive(1, 5'd0, 5'd0, 5'd9, 0, 1, 1, 0, 0, 4'h1, 32'h10);
    chk_stall(0); cap(2'b00, 2'b11); tick("addi_r9");

    // Reset arriving mid-stall drops the hazard and the shadow
    drive(1, 5'd1, 5'd0, 5'd7, 0, 1, 1, 1, 0, 4'h0, 32'hC);
    cap(2'b00, 2'b11); tick("lw_r7_c");
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 1, 0, 0, 4'h1, 32'h0);
    chk_stall(1);
    rst_n = 1'b0;
    chk_stall(0); bub(1); tick("mid_reset");
`ifdef STALL_CNT_EN
    check("mid_reset.stall_cnt", stall_cnt, 32'd0);
    check("mid_reset.flush_cnt", flush_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    chk_stall(0); cap(2'b00, 2'b00); tick("post_reset");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
